bcd2hex: RTL and testbench
==========================

BCD2HEX -- requirements
Module: bcd2hex

Interface
REQ-001 SHALL have parameter input_size_in_digits, default 3, the number of packed BCD digits on bcd_in.
REQ-002 SHALL have parameter output_size_in_bits, default 10, the binary result width; the instantiator sets it to at least ceil(log2(10^input_size_in_digits)).
REQ-003 SHALL have port clock  input  1  rising-edge clock; the single clock for all state.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request to convert bcd_in; sampled on the rising edge of clock.
REQ-006 SHALL have port bcd_in  input  input_size_in_digits*4  packed BCD, least significant digit in bits [3:0].
REQ-007 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking hex_out (and error) valid.
REQ-009 SHALL have port hex_out  output  output_size_in_bits  binary result; held until the next done.
REQ-010 SHALL have port error  output  1  invalid-digit flag; updated together with done.

Function
REQ-011 SHALL implement reverse double-dabble using a register of input_size_in_digits*4 + output_size_in_bits bits: BCD field in the upper part, binary field in the lower part.
REQ-012 SHALL use states IDLE, SHIFT, ADJUST and DONE.
REQ-013 In IDLE with start=1: SHALL load bcd_in into the BCD field, clear the binary field, load bit counter = output_size_in_bits, set busy=1 and go to SHIFT.
REQ-014 In SHIFT: SHALL shift the whole register right one bit, decrement the counter and go to ADJUST.
REQ-015 In ADJUST: SHALL subtract 3 from every BCD nybble whose value is >= 8; all nybbles SHALL be evaluated from pre-adjust values in the same cycle.
REQ-016 ADJUST transitions: SHALL go to DONE if the counter is 0, else back to SHIFT.
REQ-017 In DONE: SHALL register hex_out from the binary field, assert done for exactly one cycle, clear busy and return to IDLE.
REQ-018 Latency: done SHALL be high in the cycle that begins 2*output_size_in_bits+1 rising edges after the edge that sampled start (21 cycles for defaults); throughput SHALL be one conversion per 2*output_size_in_bits+2 cycles.
REQ-019 start while busy=1 SHALL be ignored; it is neither queued nor allowed to disturb bcd_in capture.
REQ-020 start high in the same cycle as done SHALL be accepted, giving back-to-back operation.
REQ-021 bcd_in SHALL be sampled only on the accept edge; later changes to bcd_in SHALL NOT affect the result.
REQ-022 If output_size_in_bits is too small for the input value, hex_out SHALL be the input value modulo 2^output_size_in_bits, with no flag raised.

Reset
REQ-023 While reset_n=0, the block SHALL asynchronously force state=IDLE, busy=0, done=0, hex_out=0, error=0, counter=0 and shift register=0.
REQ-024 On release of reset_n, the block SHALL start operation from IDLE on the next rising edge; assertion mid-conversion SHALL abandon that conversion with no done.

Configuration
REQ-025 Macro BCD2HEX_INVALID_DIGIT_CHECK_EN, when defined: at accept, SHALL record whether any bcd_in nybble > 9, and present that flag on error in the same cycle as done.
REQ-026 Macro BCD2HEX_INVALID_DIGIT_CHECK_EN, when defined: error SHALL hold its value until the next done.
REQ-027 Macro BCD2HEX_INVALID_DIGIT_CHECK_EN, when not defined: error SHALL be constant 0 and no check logic SHALL be built.
REQ-028 In both configurations, conversion of an invalid input SHALL run to completion with normal timing; hex_out is then unspecified.

Verification
REQ-029 Defaults, bcd_in=0x999, start pulse -> done after 21 cycles, hex_out=0x3E7, error=0.
REQ-030 Defaults, bcd_in=0x000, then bcd_in=0x255 issued back-to-back (start held high across done) -> hex_out=0x000, then hex_out=0x0FF, 22 cycles apart.
REQ-031 bcd_in=0x1A3 with macro defined -> error=1 with done; without macro -> error=0, done still at 21 cycles.
REQ-032 start=1 pulsed at cycles 5 and 10 after an accepted start of 0x123 -> a single done, hex_out=0x07B.
REQ-033 reset_n driven low at cycle 8 of a conversion -> busy, done, hex_out and error at 0 immediately; no done until a new start.
REQ-034 input_size_in_digits=4, output_size_in_bits=14, bcd_in=0x9999 -> done after 29 cycles, hex_out=0x270F.

Source files
------------

// File: rtl/bcd2hex.sv
// Packed-BCD to binary converter using reverse double-dabble (shift right, then
// subtract 3 from any BCD nybble >= 8). Optional macro: BCD2HEX_INVALID_DIGIT_CHECK_EN.
module bcd2hex #(
   parameter int input_size_in_digits = 3,
   parameter int output_size_in_bits  = 10
) (
   input  logic                              clock,
   input  logic                              reset_n,
   input  logic                              start,
   input  logic [input_size_in_digits*4-1:0] bcd_in,
   output logic                              busy,
   output logic                              done,
   output logic [output_size_in_bits-1:0]    hex_out,
   output logic                              error
);

   localparam int bcd_w = input_size_in_digits * 4;
   localparam int reg_w = bcd_w + output_size_in_bits;
   localparam int cnt_w = $clog2(output_size_in_bits + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, ADJUST, DONE} state_t;

   state_t                           state, state_next;
   logic [reg_w-1:0]                 shreg, shreg_next, shreg_adj;
   logic [cnt_w-1:0]                 cnt, cnt_next;
   logic                             busy_next, done_next;
   logic [output_size_in_bits-1:0]   hex_next;
   logic                             accept;

   assign accept = (state == IDLE) && start;

   // Every BCD nybble is corrected from its pre-adjust value in one cycle.
   always_comb begin
      logic [3:0] nyb;
      shreg_adj = shreg;
      for (int i = 0; i < input_size_in_digits; i++) begin
         nyb = shreg[output_size_in_bits + 4*i +: 4];
         if (nyb >= 4'd8)
            shreg_adj[output_size_in_bits + 4*i +: 4] = nyb - 4'd3;
      end
   end

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      state_next = state;
      shreg_next = shreg;
      cnt_next   = cnt;
      busy_next  = busy;
      done_next  = 1'b0;
      hex_next   = hex_out;
      case (state)
         IDLE: begin
            if (start) begin
               shreg_next = {bcd_in, {output_size_in_bits{1'b0}}};
               cnt_next   = cnt_w'(output_size_in_bits);
               busy_next  = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            shreg_next = shreg >> 1;
            cnt_next   = cnt - cnt_w'(1);
            state_next = ADJUST;
         end
         ADJUST: begin
            shreg_next = shreg_adj;
            state_next = (cnt == '0) ? DONE : SHIFT;
         end
         DONE: begin
            hex_next   = shreg[output_size_in_bits-1:0];
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         shreg   <= '0;
         cnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         hex_out <= '0;
      end else begin
         state   <= state_next;
         shreg   <= shreg_next;
         cnt     <= cnt_next;
         busy    <= busy_next;
         done    <= done_next;
         hex_out <= hex_next;
      end
   end

`ifdef BCD2HEX_INVALID_DIGIT_CHECK_EN
   logic bad_digit;
   logic bad_pending;

   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < input_size_in_digits; i++)
         if (bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
   end

   // Flag is captured with the operand and published alongside done.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bad_pending <= 1'b0;
         error       <= 1'b0;
      end else begin
         if (accept)        bad_pending <= bad_digit;
         if (state == DONE) error       <= bad_pending;
      end
   end
`else
   logic unused_accept;
   assign unused_accept = accept;
   assign error         = 1'b0;
`endif

endmodule

// File: tb/tb_bcd2hex.sv
// Self-checking bench for bcd2hex: arithmetic reference model with a per-cycle
// compare process, directed literal cases and a randomized stimulus phase.
`timescale 1ns/1ps
module tb_bcd2hex;

   localparam int ND = 3;
   localparam int OW = 10;
   localparam int LAT = 2*OW + 1;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [ND*4-1:0] bcd_in = '0;
   logic          busy, done, error;
   logic [OW-1:0] hex_out;

   logic          start2 = 1'b0;
   logic [15:0]   bcd_in2 = '0;
   logic          busy2, done2, error2;
   logic [13:0]   hex_out2;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   bcd2hex #(.input_size_in_digits(ND), .output_size_in_bits(OW)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .bcd_in(bcd_in),
      .busy(busy), .done(done), .hex_out(hex_out), .error(error));

   bcd2hex #(.input_size_in_digits(4), .output_size_in_bits(14)) dut2 (
      .clock(clock), .reset_n(reset_n), .start(start2), .bcd_in(bcd_in2),
      .busy(busy2), .done(done2), .hex_out(hex_out2), .error(error2));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int            cyc = 0;
   int            accept_at = -1;
   int            done_at = -1;
   logic [OW-1:0] held_hex = '0, pend_hex;
   bit            held_known = 1'b1, pend_known;
   bit            held_err = 1'b0, pend_err;

   task automatic model_convert(input logic [ND*4-1:0] b);
      int  value;
      bit  invalid;
      int  d;
      value = 0;
      invalid = 1'b0;
      for (int i = ND-1; i >= 0; i--) begin
         d = int'(b[4*i +: 4]);
         if (d > 9) invalid = 1'b1;
         value = value*10 + d;
      end
      pend_hex   = OW'(value % (1 << OW));
      pend_known = !invalid;
`ifdef BCD2HEX_INVALID_DIGIT_CHECK_EN
      pend_err = invalid;
`else
      pend_err = 1'b0;
`endif
   endtask

   always @(negedge reset_n) begin
      accept_at  = -1;
      done_at    = -1;
      held_hex   = '0;
      held_known = 1'b1;
      held_err   = 1'b0;
   end

   always @(posedge clock) begin
      if (reset_n) begin
         cyc++;
         if (cyc == done_at) begin
            held_hex   = pend_hex;
            held_known = pend_known;
            held_err   = pend_err;
         end
         if (start && (done_at < 0 || cyc > done_at)) begin
            accept_at = cyc;
            done_at   = cyc + LAT;
            model_convert(bcd_in);
         end
      end
   end

   always @(posedge clock) begin
      #3;
      check("busy", busy, (accept_at >= 0 && cyc >= accept_at && cyc < done_at));
      check("done", done, (done_at >= 0 && cyc == done_at));
      check("error", error, held_err);
      if (held_known) check("hex_out", hex_out, held_hex);
   end

   // ---------------- directed helpers ----------------
   task automatic wait_done(output int lat, output logic [OW-1:0] h);
      lat = 0;
      h = '0;
      forever begin
         @(posedge clock);
         lat++;
         #2;
         if (done) begin
            h = hex_out;
            return;
         end
         if (lat > 200) begin
            check("done_timeout", 0, 1);
            return;
         end
      end
   endtask

   function automatic logic [ND*4-1:0] rand_bcd();
      logic [ND*4-1:0] b;
      for (int i = 0; i < ND; i++) begin
         b[4*i +: 4] = 4'($urandom_range(0, 9));
         if ($urandom_range(0, 19) == 0) b[4*i +: 4] = 4'($urandom_range(10, 15));
      end
      return b;
   endfunction

   initial begin
      int lat, lat2, ndone;
      logic [OW-1:0] h, h2;

      repeat (3) @(posedge clock);
      #2;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_hex", hex_out, 0);
      check("rst_err", error, 0);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (2) @(posedge clock);

      // 999 -> 0x3E7 after 21 cycles
      #1; start = 1'b1; bcd_in = 12'h999;
      @(posedge clock); #1; start = 1'b0; bcd_in = 12'h000;
      wait_done(lat, h);
      check("lat_999", lat, 21);
      check("hex_999", h, 10'h3E7);
      check("err_999", error, 0);

      // back-to-back 000 then 255 with start held high
      @(posedge clock); #1; start = 1'b1; bcd_in = 12'h000;
      @(posedge clock);
      wait_done(lat, h);
      check("lat_000", lat, 21);
      check("hex_000", h, 10'h000);
      bcd_in = 12'h255;
      wait_done(lat2, h2);
      start = 1'b0;
      check("b2b_gap", lat2, 22);
      check("hex_255", h2, 10'h0FF);

      // invalid digit: normal timing, flag only when the check is built
      @(posedge clock); #1; start = 1'b1; bcd_in = 12'h1A3;
      @(posedge clock); #1; start = 1'b0;
      wait_done(lat, h);
      check("lat_1a3", lat, 21);
`ifdef BCD2HEX_INVALID_DIGIT_CHECK_EN
      check("err_1a3", error, 1);
`else
      check("err_1a3", error, 0);
`endif

      // starts while busy are ignored; later bcd_in changes do not matter
      @(posedge clock); #1; start = 1'b1; bcd_in = 12'h123;
      @(posedge clock);
      ndone = 0; lat = 0; h = '0;
      for (int k = 1; k <= 45; k++) begin
         #1;
         start  = (k == 1 || k == 5 || k == 10);
         if (k == 1) start = 1'b0;
         bcd_in = rand_bcd();
         @(posedge clock);
         #2;
         if (done) begin ndone++; lat = k; h = hex_out; end
      end
      start = 1'b0;
      check("ignore_ndone", ndone, 1);
      check("ignore_lat", lat, 21);
      check("hex_123", h, 10'h07B);

      // reset mid-conversion abandons it
      @(posedge clock); #1; start = 1'b1; bcd_in = 12'h999;
      @(posedge clock); #1; start = 1'b0;
      repeat (7) @(posedge clock);
      #1; reset_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_hex", hex_out, 0);
      check("mid_rst_err", error, 0);
      repeat (3) @(posedge clock);
      #1; reset_n = 1'b1;
      ndone = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clock); #2;
         if (done) ndone++;
      end
      check("post_rst_ndone", ndone, 0);

      // wider instance: 9999 -> 0x270F after 29 cycles
      #1; start2 = 1'b1; bcd_in2 = 16'h9999;
      @(posedge clock); #1; start2 = 1'b0; bcd_in2 = 16'h0000;
      lat = 0;
      while (lat <= 100) begin
         @(posedge clock); lat++; #2;
         if (done2) break;
      end
      check("lat_9999", lat, 29);
      check("hex_9999", hex_out2, 14'h270F);

      // randomized phase, checked every cycle by the compare process
      for (int k = 0; k < 3000; k++) begin
         @(posedge clock); #1;
         start  = ($urandom_range(0, 5) == 0);
         bcd_in = rand_bcd();
      end
      #1; start = 1'b0;
      repeat (30) @(posedge clock);
      #5;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
